// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Round-robin arbiter giving NUM_REQ requesters timed turns on
//               a shared 8-digit hex display.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [NUM_REQ-1:0]     req_in,
   input  logic [32*NUM_REQ-1:0]  val_in,
   input  logic [8*NUM_REQ-1:0]   en_in,
   output logic [31:0]            bin_out,
   output logic [7:0]             enable_out,
   output logic [NUM_REQ-1:0]     grant_out,
   output logic [NUM_REQ-1:0]     done_out,
   output logic                   busy_out
);

   localparam int                 c_CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam int                 c_PTR_W = $clog2(NUM_REQ);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
   localparam logic [NUM_REQ-1:0] c_ONE   = NUM_REQ'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]         r_state, w_state_nxt;
   logic [c_PTR_W-1:0] r_ptr, w_ptr_nxt;
   logic [c_PTR_W-1:0] r_owner, w_owner_nxt;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [c_PTR_W-1:0] w_win, w_idx;
   logic               w_found, w_last;
   logic [31:0]        w_bin_nxt;
   logic [7:0]         w_en_nxt;
   logic [NUM_REQ-1:0] w_grant_nxt, w_done_nxt;
   logic [31:0]        w_vals [NUM_REQ];
   logic [7:0]         w_ens  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_vals[g] = val_in[32*g +: 32];
      assign w_ens[g]  = en_in[8*g +: 8];
   end

   // Search upward from the pointer, wrapping; first set request wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = c_PTR_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_found && req_in[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_last = (r_cnt == c_LAST);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_cnt      <= '0;
         bin_out    <= '0;
         enable_out <= 8'h00;
         grant_out  <= '0;
         done_out   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_owner    <= w_owner_nxt;
         r_cnt      <= w_cnt_nxt;
         bin_out    <= w_bin_nxt;
         enable_out <= w_en_nxt;
         grant_out  <= w_grant_nxt;
         done_out   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_nxt = S_HOLD;
         S_HOLD:  if (w_last)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_bin_nxt   = bin_out;
      w_en_nxt    = enable_out;
      w_grant_nxt = '0;
      w_done_nxt  = '0;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      if (r_state == S_IDLE) begin
         if (w_found) begin
            w_bin_nxt   = w_vals[w_win];
            w_en_nxt    = w_ens[w_win];
            w_grant_nxt = c_ONE << w_win;
            w_cnt_nxt   = '0;
            w_owner_nxt = w_win;
         end
      end else if (w_last) begin
         // The finishing requester drops to lowest priority.
         w_done_nxt = c_ONE << r_owner;
         w_ptr_nxt  = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   assign busy_out = (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the 8-digit hex display (range 2..8).
REQ-002 Parameter HOLD_CYCLES, default 50_000_000, SHALL set the clk_in cycles one granted value stays on the display (minimum 1).
REQ-003 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 req_in  input  NUM_REQ  SHALL carry per-requester display requests, level-held until granted.
REQ-006 val_in  input  32*NUM_REQ  SHALL carry the packed values, requester i in bits [32i+31:32i].
REQ-007 en_in  input  8*NUM_REQ  SHALL carry the packed digit enables, requester i in bits [8i+7:8i].
REQ-008 bin_out  output  32  SHALL be the value driven to the display driver's bin_in.
REQ-009 enable_out  output  8  SHALL be the digit enables driven to the display driver's enable_in.
REQ-010 grant_out  output  NUM_REQ  SHALL be a one-hot, one-cycle acknowledge that requester i's value was latched.
REQ-011 done_out  output  NUM_REQ  SHALL be a one-hot, one-cycle pulse marking the end of requester i's hold window.
REQ-012 busy_out  output  1  SHALL be high whenever the FSM is in HOLD.

Function
REQ-013 The FSM SHALL have two states, IDLE and HOLD; all outputs SHALL be registered.
REQ-014 In IDLE with req_in == 0, the FSM SHALL stay in IDLE; bin_out and enable_out SHALL hold their last values.
REQ-015 In IDLE with any req_in bit set, arbitration SHALL be round-robin: the winner is the first set bit at or above pointer rr_ptr, searching upward and wrapping modulo NUM_REQ.
REQ-016 On the edge following an IDLE cycle with a winner w, the block SHALL do all of the following:
- set state to HOLD;
- load bin_out and enable_out from w's slices;
- set grant_out to (1 << w) for exactly one cycle;
- clear the hold counter to 0.
REQ-017 Request-to-grant latency SHALL be 1 cycle; val_in and en_in SHALL be sampled only in the arbitration cycle.
REQ-018 In HOLD, the counter SHALL increment by 1 per cycle; it SHALL be $clog2(HOLD_CYCLES+1) bits wide and never wrap.
REQ-019 In HOLD, req_in, val_in and en_in SHALL be ignored, and bin_out and enable_out SHALL stay constant.
REQ-020 In HOLD, when counter == HOLD_CYCLES-1, the next edge SHALL do all of the following:
- set state to IDLE;
- set done_out to (1 << w) for one cycle;
- set rr_ptr to (w+1) mod NUM_REQ.
REQ-021 The display window from grant_out high to done_out high SHALL be exactly HOLD_CYCLES cycles.
REQ-022 A request pending at the HOLD->IDLE edge SHALL be arbitrated in the first IDLE cycle, so back-to-back grants are separated by exactly one IDLE cycle.
REQ-023 A requester whose req_in drops before grant SHALL NOT be granted; a requester holding req_in through its done_out SHALL be treated as a new request, ranking last behind the others.
REQ-024 grant_out and done_out SHALL never be high in the same cycle; busy_out SHALL equal (state == HOLD).
REQ-025 For HOLD_CYCLES == 1, each HOLD state SHALL last exactly one cycle.

Reset
REQ-026 When rst_in is high at a rising edge, the block SHALL set all of the following, regardless of state:
- state = IDLE, rr_ptr = 0, counter = 0;
- bin_out = 0, enable_out = 8'h00 (display blank);
- grant_out = 0, done_out = 0, busy_out = 0.
REQ-027 Reset mid-HOLD SHALL abort the window with no done_out pulse; the first post-reset arbitration SHALL start from requester 0.

Verification (NUM_REQ=4, HOLD_CYCLES=4)
REQ-028 Reset, then req_in=4'b0010, val_in[63:32]=32'hDEAD_BEEF, en_in[15:8]=8'hFF -> next cycle grant_out=4'b0010, bin_out=32'hDEADBEEF, enable_out=8'hFF, busy_out=1; done_out=4'b0010 four cycles after grant.
REQ-029 req_in=4'b1111 held continuously -> grants in order 0,1,2,3,0, each 5 cycles apart (4 HOLD + 1 IDLE).
REQ-030 During requester 0's HOLD, change val_in[31:0] and raise req_in[2] -> bin_out unchanged until the next grant; requester 2 granted one cycle after done_out[0].
REQ-031 Assert rst_in in the 2nd HOLD cycle -> next cycle bin_out=0, enable_out=0, busy_out=0, no done_out; then req_in=4'b1001 -> requester 0 granted first.
REQ-032 Pulse req_in[3] for one cycle while busy_out=1 -> no grant to requester 3 after done_out.
REQ-033 Rerun REQ-029 with HOLD_CYCLES=1 -> grant/done pairs alternate with one IDLE gap; the two pulses never overlap.
